// File: rtl/usart_tx.sv
// usart_tx: 16x-oversampled async transmitter, 8 data bits LSB first, 1 stop bit, one-byte holding register.
// Define USART_TX_PARITY_EN to add an even parity bit (8E1); the default build is 8N1.

module usart_tx (
    input  logic       bit_clock_x16,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       tx_pin
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef USART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       holding_full_q, holding_full_d;
    logic       tx_q, tx_d;
`ifdef USART_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif
    logic       bit_end;
    logic       transfer;

    always_comb begin
        state_d        = state_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        hold_d         = hold_q;
        holding_full_d = holding_full_q;
        tx_d           = tx_q;
`ifdef USART_TX_PARITY_EN
        parity_d       = parity_q;
`endif
        transfer       = 1'b0;
        bit_end        = (tick_q == 4'd15);
        tick_d         = (state_q == IDLE) ? 4'd0 : tick_q + 4'd1;

        // Accept only into an empty holding register; transfer only from a full one.
        if (load && !holding_full_q) begin
            hold_d         = data_in;
            holding_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (holding_full_q) transfer = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef USART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef USART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (holding_full_q) begin
                        transfer = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (transfer) begin
            shift_d        = hold_q;
            holding_full_d = 1'b0;
            state_d        = START;
            tick_d         = 4'd0;
            tx_d           = 1'b0;
`ifdef USART_TX_PARITY_EN
            parity_d       = ^hold_q;
`endif
        end
    end

    always_ff @(posedge bit_clock_x16) begin
        if (reset) begin
            state_q        <= IDLE;
            tick_q         <= 4'd0;
            bit_idx_q      <= 3'd0;
            shift_q        <= 8'd0;
            hold_q         <= 8'd0;
            holding_full_q <= 1'b0;
            tx_q           <= 1'b1;
`ifdef USART_TX_PARITY_EN
            parity_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            tick_q         <= tick_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            hold_q         <= hold_d;
            holding_full_q <= holding_full_d;
            tx_q           <= tx_d;
`ifdef USART_TX_PARITY_EN
            parity_q       <= parity_d;
`endif
        end
    end

    assign ready  = !holding_full_q;
    assign busy   = (state_q != IDLE) || holding_full_q;
    assign tx_pin = tx_q;

endmodule

// File: tb/tb_usart_tx.sv
// Bench for usart_tx: transaction-level model predicts transfers into a scoreboard; a line monitor decodes frames.

module tb_usart_tx;

`ifdef USART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       load = 1'b0;
    logic       ready, busy, tx_pin;

    usart_tx dut (
        .bit_clock_x16 (clk),
        .reset         (reset),
        .data_in       (data_in),
        .load          (load),
        .ready         (ready),
        .busy          (busy),
        .tx_pin        (tx_pin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        int unsigned c;
    } frame_t;

    frame_t      sb[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 1'b0;

    // Model: one holding slot plus a count of edges left in the frame on the line.
    bit          m_hold = 1'b0;
    logic [7:0]  m_data = 8'd0;
    int          m_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    always @(posedge clk) begin
        bit acc, xfer;
        cyc++;
        if (reset) begin
            m_hold = 1'b0;
            m_left = 0;
            sb.delete();
        end else begin
            acc  = load && !m_hold;
            xfer = m_hold && (m_left <= 1);
            if (xfer) begin
                sb.push_back('{m_data, cyc});
                m_left = FRAME;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (acc) begin
                m_hold = 1'b1;
                m_data = data_in;
            end else if (xfer) begin
                m_hold = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", ready, !m_hold);
            check("busy", busy, (m_left > 0) || m_hold);
        end
    end

    logic s [NB*16];

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!(reset || tx_pin !== 1'b0)) begin
                int unsigned start_cyc;
                bit          abort, stable;
                logic [NB-1:0] bits;
                frame_t      e;
                start_cyc = cyc;
                abort     = 1'b0;
                s[0]      = tx_pin;
                for (int i = 1; i < NB*16; i++) begin
                    @(negedge clk);
                    if (reset) begin
                        abort = 1'b1;
                        break;
                    end
                    s[i] = tx_pin;
                end
                if (!abort) begin
                    stable = 1'b1;
                    for (int b = 0; b < NB; b++) begin
                        bits[b] = s[b*16];
                        for (int c = 0; c < 16; c++)
                            if (s[b*16+c] !== bits[b]) stable = 1'b0;
                    end
                    if (sb.size() == 0) begin
                        fail_now("unexpected_frame");
                    end else begin
                        e = sb.pop_front();
                        check("bit_stable", stable, 1'b1);
                        check("start_cycle", start_cyc, e.c);
                        check("data", bits[8:1], e.d);
`ifdef USART_TX_PARITY_EN
                        check("parity", bits[9], ^e.d);
`endif
                        check("stop", bits[NB-1], 1'b1);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (m_hold && n < 3*FRAME) begin
            @(negedge clk);
            n++;
        end
        if (m_hold) fail_now("send_timeout");
        load    = 1'b1;
        data_in = b;
        @(negedge clk);
        load    = 1'b0;
        data_in = $urandom_range(0, 255);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_hold || m_left > 0) && n < 4*FRAME) begin
            @(negedge clk);
            n++;
        end
        if (m_hold || m_left > 0) fail_now("idle_timeout");
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_tx", tx_pin, 1'b1);
        check("reset_ready", ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        chk_en = 1'b1;

        send(8'h75);
        wait_idle();

        // Second byte queued as soon as the slot frees, then a load that must be ignored.
        send(8'h75);
        send(8'hF5);
        @(negedge clk);
        if (m_hold) begin
            load    = 1'b1;
            data_in = 8'h00;
            @(negedge clk);
            load    = 1'b0;
        end
        wait_idle();

        for (int k = 0; k < 24; k++) begin
            send(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(150, 250)) @(negedge clk);
            else repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_idle();

        // Reset in the middle of data bit 3 with a byte queued.
        send(8'hA5);
        send(8'h3C);
        n = 0;
        while (m_left != FRAME - 72 && n < 3*FRAME) begin
            @(negedge clk);
            n++;
        end
        if (m_left != FRAME - 72) fail_now("bit3_timeout");
        reset = 1'b1;
        @(negedge clk);
        check("midreset_tx", tx_pin, 1'b1);
        check("midreset_ready", ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2*FRAME) @(negedge clk);
        check("post_reset_tx", tx_pin, 1'b1);

        check("frames_pending", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
